prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 150 +++++++++++++++
 tb/tb_prog_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - host-stream program loader into RAM via MAR/RAM strobes; LOADER_CHECKSUM_EN adds a trailing checksum byte
module prog_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       marwa,
  output logic       ramwa,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    DRV_ADDR  = 3'd2,
    DRV_DATA  = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    CHECK     = 3'd4,
`endif
    FINISH    = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr;
  logic [7:0]    data_q;
  logic          at_last;

  assign at_last = (addr == LAST_ADDR);

  // State register; reset aborts any session without a done pulse
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and bus outputs; the bus is only driven in the two drive states
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    bus_out    = 8'h00;
    bus_oe     = 1'b0;
    marwa      = 1'b0;
    ramwa      = 1'b0;
    cpu_hold   = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cpu_hold = 1'b0;
        busy     = 1'b0;
        if (start) state_nxt = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = DRV_ADDR;
      end
      DRV_ADDR: begin
        bus_out   = 8'(addr);
        bus_oe    = 1'b1;
        marwa     = 1'b1;
        state_nxt = DRV_DATA;
      end
      DRV_DATA: begin
        bus_out = data_q;
        bus_oe  = 1'b1;
        ramwa   = 1'b1;
        if (!at_last) begin
          state_nxt = WAIT_BYTE;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = FINISH;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = FINISH;
      end
`endif
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address counter and latched data byte; the address saturates at the last location
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      addr   <= '0;
      data_q <= 8'h00;
    end else begin
      if (state == IDLE && start) begin
        addr <= '0;
      end else if (state == DRV_DATA && !at_last) begin
        addr <= addr + 1'b1;
      end
      if (state == WAIT_BYTE && byte_valid) begin
        data_q <= byte_in;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;

  // Running modulo-256 sum of data bytes and sticky mismatch flag, both cleared by a new session
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sum_q <= 8'h00;
      err_q <= 1'b0;
    end else if (state == IDLE && start) begin
      sum_q <= 8'h00;
      err_q <= 1'b0;
    end else if (state == WAIT_BYTE && byte_valid) begin
      sum_q <= sum_q + byte_in;
    end else if (state == CHECK && byte_valid && (byte_in != sum_q)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against a cycle-schedule model
module tb_prog_loader;

  localparam int DEPTH = 16;
`ifdef LOADER_CHECKSUM_EN
  localparam int EXP_LEN = 3 * DEPTH + 3;
`else
  localparam int EXP_LEN = 3 * DEPTH + 2;
`endif

  logic       clk;
  logic       clr;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       marwa;
  logic       ramwa;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;

  prog_loader #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk(clk), .clr(clr), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .bus_out(bus_out), .bus_oe(bus_oe), .marwa(marwa),
    .ramwa(ramwa), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t act=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  // Reference model: expected strobes are a schedule of (cycle, kind, value) events
  typedef struct {
    int         cyc;
    bit         is_ram;
    logic [7:0] val;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  bit         m_busy = 0;
  bit         m_check = 0;
  bit         m_err = 0;
  int         m_wait_until = 0;
  int         m_done_cyc = -1;
  int         m_n = 0;
  int         m_start_cyc = 0;
  logic [7:0] m_sum = 8'h00;
  int         done_cnt = 0;
  int         mar_cnt = 0;
  int         obs_len = 0;
  logic       e_mar, e_ram, e_ready, e_busy, e_done, e_err, e_oe;
  logic [7:0] e_bus;
  ev_t        ev;

  // Compare DUT outputs with the model every cycle, then advance the model
  always @(negedge clk) begin
    e_mar = 1'b0; e_ram = 1'b0; e_bus = 8'h00;
    if (evq.size() > 0 && evq[0].cyc == cyc) begin
      ev = evq.pop_front();
      if (ev.is_ram) e_ram = 1'b1; else e_mar = 1'b1;
      e_bus = ev.val;
    end
    e_busy  = m_busy;
    e_ready = m_busy && (cyc >= m_wait_until) && (m_done_cyc < 0);
    e_done  = (cyc == m_done_cyc);
    e_err   = m_err;
    if (clr !== 1'b1) begin
      e_mar = 0; e_ram = 0; e_bus = 0; e_busy = 0; e_ready = 0; e_done = 0; e_err = 0;
    end
    e_oe = e_mar | e_ram;
    chk("byte_ready", byte_ready, e_ready);
    chk("busy", busy, e_busy);
    chk("cpu_hold", cpu_hold, e_busy);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("marwa", marwa, e_mar);
    chk("ramwa", ramwa, e_ram);
    chk("bus_oe", bus_oe, e_oe);
    chk("bus_out", bus_out, e_bus);
    if (done === 1'b1) begin
      done_cnt++;
      obs_len = cyc - m_start_cyc + 1;
    end
    if (marwa === 1'b1) mar_cnt++;

    if (clr !== 1'b1) begin
      m_busy = 0; m_check = 0; m_err = 0; m_done_cyc = -1; evq.delete();
    end else if (!m_busy) begin
      if (start === 1'b1) begin
        m_busy = 1; m_check = 0; m_err = 0; m_n = 0; m_sum = 8'h00;
        m_wait_until = cyc + 1; m_done_cyc = -1; m_start_cyc = cyc; evq.delete();
      end
    end else if (cyc == m_done_cyc) begin
      m_busy = 0; m_done_cyc = -1;
    end else if (e_ready && byte_valid === 1'b1) begin
      if (m_check) begin
        m_err = (byte_in != m_sum);
        m_done_cyc = cyc + 1;
      end else begin
        evq.push_back('{cyc + 1, 1'b0, 8'(m_n)});
        evq.push_back('{cyc + 2, 1'b1, byte_in});
        m_sum = m_sum + byte_in;
        m_n++;
        if (m_n < DEPTH) begin
          m_wait_until = cyc + 3;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          m_check = 1; m_wait_until = cyc + 3;
`else
          m_done_cyc = cyc + 3;
`endif
        end
      end
    end
    cyc++;
  end

  logic [7:0] src[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_cksum(input bit corrupt);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    foreach (src[i]) s = s + src[i];
    src.push_back(s ^ {7'd0, corrupt});
`else
    if (corrupt) src.push_back(8'h00);
    if (corrupt) void'(src.pop_back());
`endif
  endtask

  task automatic begin_session(input bit hold);
    start = 1'b1;
    byte_valid = 1'b0;
    step();
    start = hold;
  endtask

  task automatic feed(input int vpct, input int stall_idx, input int pulse_idx,
                      input int abort_idx, input bit hold_start, output bit aborted);
    int acc_n, budget, d0, stall_left;
    bit acc, pulsed, pulse_now;
    acc_n = 0; budget = 3000; d0 = done_cnt; stall_left = 4; pulsed = 0; aborted = 0;
    while (done_cnt == d0 && budget > 0) begin
      if (abort_idx >= 0 && acc_n == abort_idx + 1 && ramwa) begin
        aborted = 1;
        break;
      end
      pulse_now = 0;
      if (pulse_idx >= 0 && !pulsed && acc_n == pulse_idx + 1 && marwa) begin
        pulse_now = 1; pulsed = 1;
      end
      start = hold_start | pulse_now;
      byte_in = (src.size() > 0) ? src[0] : 8'($urandom);
      if (acc_n == stall_idx && stall_left > 0 && byte_ready) begin
        byte_valid = 1'b0;
        stall_left--;
        chk("stall_ready", byte_ready, 1);
        chk("stall_strobes", {marwa, ramwa}, 0);
        chk("stall_hold", cpu_hold, 1);
      end else begin
        byte_valid = (src.size() > 0) && ($urandom_range(0, 99) < vpct);
      end
      acc = byte_valid && byte_ready;
      step();
      if (acc) begin
        void'(src.pop_front());
        acc_n++;
      end
      budget--;
    end
    byte_valid = 1'b0;
    start = hold_start;
    if (budget == 0) chk("feed_timeout", 0, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bit ab;
    int d0, m0;
    bit hold;
    clr = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_bus", {bus_oe, bus_out}, 0);
    chk("rst_strobes", {marwa, ramwa, done, err, byte_ready}, 0);
    clr = 1'b1;
    step();

    // Full load, always valid
    src.delete();
    for (int k = 0; k < DEPTH; k++) src.push_back(8'h1E + 8'(8'h11 * k));
    add_cksum(0);
    d0 = done_cnt; m0 = mar_cnt;
    begin_session(0);
    feed(100, -1, -1, -1, 0, ab);
    chk("full_len", obs_len, EXP_LEN);
    chk("full_done_cnt", done_cnt - d0, 1);
    chk("full_mar_cnt", mar_cnt - m0, DEPTH);

    // Backpressure before byte 3
    src.delete();
    for (int k = 0; k < DEPTH; k++) src.push_back(8'hA0 + 8'(k));
    add_cksum(0);
    begin_session(0);
    feed(100, 3, -1, -1, 0, ab);
    chk("stall_len", obs_len, EXP_LEN + 4);

    // Reset mid DRV_DATA at addr 5, then reload from 0
    src.delete();
    for (int k = 0; k < DEPTH; k++) src.push_back(8'($urandom));
    begin_session(0);
    feed(100, -1, -1, 5, 0, ab);
    chk("abort_reached", ab, 1);
    chk("abort_at_data5", {ramwa, bus_oe}, 2'b11);
    clr = 1'b0;
    #1;
    chk("abort_zero", {bus_out, bus_oe, marwa, ramwa, cpu_hold, busy, done, err, byte_ready}, 0);
    d0 = done_cnt;
    repeat (3) step();
    chk("abort_no_done", done_cnt - d0, 0);
    clr = 1'b1;
    step();
    src.delete();
    for (int k = 0; k < DEPTH; k++) src.push_back(8'($urandom));
    add_cksum(0);
    m0 = mar_cnt;
    begin_session(0);
    feed(100, -1, -1, -1, 0, ab);
    chk("reload_len", obs_len, EXP_LEN);
    chk("reload_mar_cnt", mar_cnt - m0, DEPTH);

    // Start pulsed while busy at addr 7
    src.delete();
    for (int k = 0; k < DEPTH; k++) src.push_back(8'($urandom));
    add_cksum(0);
    d0 = done_cnt; m0 = mar_cnt;
    begin_session(0);
    feed(100, -1, 7, -1, 0, ab);
    repeat (4) step();
    chk("busy_start_done_cnt", done_cnt - d0, 1);
    chk("busy_start_mar_cnt", mar_cnt - m0, DEPTH);
    chk("busy_start_idle", busy, 0);

`ifdef LOADER_CHECKSUM_EN
    src.delete();
    for (int k = 1; k <= DEPTH; k++) src.push_back(8'(k));
    src.push_back(8'h88);
    begin_session(0);
    feed(100, -1, -1, -1, 0, ab);
    chk("cksum_good_err", err, 0);
    src.delete();
    for (int k = 1; k <= DEPTH; k++) src.push_back(8'(k));
    src.push_back(8'h89);
    begin_session(0);
    feed(100, -1, -1, -1, 0, ab);
    chk("cksum_bad_err", err, 1);
    begin_session(0);
    chk("cksum_err_cleared", err, 0);
    clr = 1'b0;
    step();
    clr = 1'b1;
    step();
`endif

    // Randomized sessions with random valid density and occasional back-to-back starts
    for (int s = 0; s < 8; s++) begin
      src.delete();
      for (int k = 0; k < DEPTH; k++) src.push_back(8'($urandom));
      add_cksum($urandom_range(0, 1) == 1);
      hold = (s < 7) && ($urandom_range(0, 1) == 1);
      d0 = done_cnt;
      begin_session(hold);
      feed($urandom_range(30, 100), -1, -1, -1, hold, ab);
      chk("rand_done_cnt", done_cnt - d0, 1);
    end
    start = 1'b0;
    repeat (3) step();
    chk("end_idle", {busy, cpu_hold}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
